// File: rtl/servo_track_pkg.sv
// Shared types for the solar-tracker servo sequencer.
//   state_t : FSM state encoding, visible on state_o
//   AXIS_*  : round-robin pointer values (pan is served first after reset)
//   dir_t   : direction code, same encoding servo_driver uses
package servo_track_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_SAMPLE = 3'd1,
    ST_EVAL        = 3'd2,
    ST_MOVE        = 3'd3,
    ST_SETTLE      = 3'd4
  } state_t;

  localparam logic AXIS_PAN  = 1'b0;
  localparam logic AXIS_TILT = 1'b1;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10
  } dir_t;

endpackage

// File: rtl/track_dir_eval.sv
// Combinational move request for one axis.
//   ldr_p, ldr_n : sensor pair; ldr_p brighter than ldr_n asks for cw
//   pos          : servo pulse-width feedback (us)
//   req          : DIR_CW / DIR_CCW / DIR_STOP after deadband and travel limits
module track_dir_eval
  import servo_track_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int DEADBAND = 64,
  parameter int POS_MIN  = 500,
  parameter int POS_MAX  = 2500
) (
  input  logic [DATA_W-1:0] ldr_p,
  input  logic [DATA_W-1:0] ldr_n,
  input  logic [31:0]       pos,
  output dir_t              req
);

  localparam logic signed [DATA_W:0] DB_P = (DATA_W+1)'(DEADBAND);
  localparam logic signed [DATA_W:0] DB_N = -DB_P;
  localparam logic [31:0] POS_MIN_U = 32'(POS_MIN);
  localparam logic [31:0] POS_MAX_U = 32'(POS_MAX);

  // One extra bit keeps the full unsigned range of the difference.
  logic signed [DATA_W:0] diff;
  assign diff = $signed({1'b0, ldr_p}) - $signed({1'b0, ldr_n});

  always_comb begin
    req = DIR_STOP;
    if (diff > DB_P && pos < POS_MAX_U)
      req = DIR_CW;
    else if (diff < DB_N && pos > POS_MIN_U)
      req = DIR_CCW;
  end

endmodule

// File: rtl/servo_track_ctrl.sv
// Pan/tilt tracking sequencer: latches a sensor set, decides which axis
// moves, grants the single move slot round-robin, holds the command for a
// fixed time (or until the travel limit) and then waits for the mechanics
// to settle.
//   CLK, RST           : clock, synchronous active-high reset
//   EN                 : tracking enable, low forces IDLE
//   sample_valid       : strobe, ldr_* valid this cycle
//   ldr_a/b, ldr_c/d   : pan (east, west) and tilt (up, down) sensor pairs
//   pan_pos, tilt_pos  : servo pulse-width feedback
//   pan_cw .. tilt_ccw : registered direction commands, at most one high
//   busy               : high in MOVE or SETTLE
//   state_o            : current state encoding
//
// state          | meaning
// IDLE        0  | tracking disabled
// WAIT_SAMPLE 1  | waiting for a sensor strobe
// EVAL        2  | compute requests, arbitrate
// MOVE        3  | granted command held high
// SETTLE      4  | all commands low, mechanics settle
module servo_track_ctrl
  import servo_track_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int DEADBAND     = 64,
  parameter int MOVE_TICKS   = 2000000,
  parameter int SETTLE_TICKS = 1000000,
  parameter int POS_MIN      = 500,
  parameter int POS_MAX      = 2500
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] ldr_a,
  input  logic [DATA_W-1:0] ldr_b,
  input  logic [DATA_W-1:0] ldr_c,
  input  logic [DATA_W-1:0] ldr_d,
  input  logic [31:0]       pan_pos,
  input  logic [31:0]       tilt_pos,
  output logic              pan_cw,
  output logic              pan_ccw,
  output logic              tilt_cw,
  output logic              tilt_ccw,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam int CNT_MAX = (MOVE_TICKS > SETTLE_TICKS) ? MOVE_TICKS : SETTLE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOVE_LAST   = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [31:0] POS_MIN_U = 32'(POS_MIN);
  localparam logic [31:0] POS_MAX_U = 32'(POS_MAX);

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic               rr_q, rr_nx;
  // {tilt_ccw, tilt_cw, pan_ccw, pan_cw}
  logic [3:0]         cmd_q, cmd_nx;
  logic               latch;
  logic [DATA_W-1:0]  s_a, s_b, s_c, s_d;
  dir_t               pan_req, tilt_req;
  logic               pan_go, tilt_go, limit_hit;

  track_dir_eval #(
    .DATA_W(DATA_W), .DEADBAND(DEADBAND), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
  ) u_pan_eval (
    .ldr_p(s_a), .ldr_n(s_b), .pos(pan_pos), .req(pan_req)
  );

  track_dir_eval #(
    .DATA_W(DATA_W), .DEADBAND(DEADBAND), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
  ) u_tilt_eval (
    .ldr_p(s_c), .ldr_n(s_d), .pos(tilt_pos), .req(tilt_req)
  );

  assign pan_go  = (pan_req != DIR_STOP);
  assign tilt_go = (tilt_req != DIR_STOP);

  // The active command itself identifies the moving axis and direction.
  assign limit_hit = (cmd_q[0] && pan_pos  >= POS_MAX_U) ||
                     (cmd_q[1] && pan_pos  <= POS_MIN_U) ||
                     (cmd_q[2] && tilt_pos >= POS_MAX_U) ||
                     (cmd_q[3] && tilt_pos <= POS_MIN_U);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= AXIS_PAN;
      cmd_q   <= '0;
      s_a     <= '0;
      s_b     <= '0;
      s_c     <= '0;
      s_d     <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      rr_q    <= rr_nx;
      cmd_q   <= cmd_nx;
      if (latch) begin
        s_a <= ldr_a;
        s_b <= ldr_b;
        s_c <= ldr_c;
        s_d <= ldr_d;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = '0;
    rr_nx    = rr_q;
    cmd_nx   = '0;
    latch    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) state_nx = ST_WAIT_SAMPLE;
      end
      ST_WAIT_SAMPLE: begin
        if (sample_valid) begin
          latch    = 1'b1;
          state_nx = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (pan_go && (!tilt_go || rr_q == AXIS_PAN)) begin
          cmd_nx[1:0] = pan_req;
          rr_nx       = AXIS_TILT;
          state_nx    = ST_MOVE;
        end else if (tilt_go) begin
          cmd_nx[3:2] = tilt_req;
          rr_nx       = AXIS_PAN;
          state_nx    = ST_MOVE;
        end else begin
          state_nx = ST_WAIT_SAMPLE;
        end
      end
      ST_MOVE: begin
        if (limit_hit || cnt_q == MOVE_LAST) begin
          state_nx = ST_SETTLE;
        end else begin
          cmd_nx = cmd_q;
          cnt_nx = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_nx = ST_WAIT_SAMPLE;
        else                      cnt_nx   = cnt_q + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!EN) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      cmd_nx   = '0;
    end
  end

  assign pan_cw   = cmd_q[0];
  assign pan_ccw  = cmd_q[1];
  assign tilt_cw  = cmd_q[2];
  assign tilt_ccw = cmd_q[3];
  assign busy     = (state_q == ST_MOVE) || (state_q == ST_SETTLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_servo_track_ctrl.sv
module tb_servo_track_ctrl;

  logic        CLK = 1'b0;
  logic        RST, EN, sample_valid;
  logic [11:0] ldr_a, ldr_b, ldr_c, ldr_d;
  logic [31:0] pan_pos, tilt_pos;
  logic        pan_cw, pan_ccw, tilt_cw, tilt_ccw, busy;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] cmd;
    logic [2:0] st;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_PCW  = 4'b0001;
  localparam logic [3:0] C_PCCW = 4'b0010;
  localparam logic [3:0] C_TCCW = 4'b1000;

  servo_track_ctrl #(
    .DATA_W(12), .DEADBAND(64), .MOVE_TICKS(8), .SETTLE_TICKS(4),
    .POS_MIN(500), .POS_MAX(2500)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .sample_valid(sample_valid),
    .ldr_a(ldr_a), .ldr_b(ldr_b), .ldr_c(ldr_c), .ldr_d(ldr_d),
    .pan_pos(pan_pos), .tilt_pos(tilt_pos),
    .pan_cw(pan_cw), .pan_ccw(pan_ccw), .tilt_cw(tilt_cw), .tilt_ccw(tilt_ccw),
    .busy(busy), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    total++;
    assert ($countones({tilt_ccw, tilt_cw, pan_ccw, pan_cw}) <= 1)
    else begin
      bad++;
      $error("FAIL onehot got=%b exp=at most one command high",
             {tilt_ccw, tilt_cw, pan_ccw, pan_cw});
    end
  end

  task automatic push(input string tag, input logic [3:0] cmd,
                      input logic [2:0] st, input int n);
    exp_t e;
    e.tag  = tag;
    e.cmd  = cmd;
    e.st   = st;
    e.busy = (st == 3'd3) || (st == 3'd4);
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    exp_t e;
    logic [3:0] cmd_obs;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmd_obs = {tilt_ccw, tilt_cw, pan_ccw, pan_cw};
        total++;
        assert (cmd_obs === e.cmd)
        else begin bad++; $error("FAIL %s cmd got=%b exp=%b", e.tag, cmd_obs, e.cmd); end
        total++;
        assert (state_o === e.st)
        else begin bad++; $error("FAIL %s state got=%0d exp=%0d", e.tag, state_o, e.st); end
        total++;
        assert (busy === e.busy)
        else begin bad++; $error("FAIL %s busy got=%b exp=%b", e.tag, busy, e.busy); end
      end
    end
  endtask

  task automatic set_ldr(input int a, input int b, input int c, input int d);
    ldr_a = 12'(a);
    ldr_b = 12'(b);
    ldr_c = 12'(c);
    ldr_d = 12'(d);
  endtask

  task automatic strobe();
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  // Strobe at WAIT_SAMPLE -> EVAL, 8 MOVE cycles, 4 SETTLE cycles, back to WAIT_SAMPLE.
  task automatic move_seq(input string tag, input logic [3:0] cmd);
    push(tag, C_NONE, 3'd2, 1);
    push(tag, cmd,    3'd3, 8);
    push(tag, C_NONE, 3'd4, 4);
    push(tag, C_NONE, 3'd1, 1);
    strobe();
    tick(13);
  endtask

  task automatic no_move(input string tag);
    push(tag, C_NONE, 3'd2, 1);
    push(tag, C_NONE, 3'd1, 2);
    strobe();
    tick(2);
  endtask

  initial begin
    RST = 1'b1;
    EN = 1'b0;
    sample_valid = 1'b0;
    set_ldr(2000, 2000, 2000, 2000);
    pan_pos = 32'd1500;
    tilt_pos = 32'd1500;

    push("reset", C_NONE, 3'd0, 2);
    tick(2);
    RST = 1'b0;
    EN = 1'b1;
    push("enable", C_NONE, 3'd1, 2);
    tick(2);

    set_ldr(1000, 800, 2000, 2000);
    move_seq("pan_only", C_PCW);

    set_ldr(864, 800, 2000, 2000);
    no_move("db_pos_edge");
    set_ldr(865, 800, 2000, 2000);
    move_seq("db_pos_over", C_PCW);
    set_ldr(800, 864, 2000, 2000);
    no_move("db_neg_edge");
    set_ldr(800, 865, 2000, 2000);
    move_seq("db_neg_over", C_PCCW);

    // Tilt-only grant leaves the pointer on pan for the contention test.
    set_ldr(2000, 2000, 800, 1000);
    move_seq("tilt_only", C_TCCW);

    set_ldr(1000, 800, 800, 1000);
    move_seq("both_1", C_PCW);
    move_seq("both_2", C_TCCW);

    pan_pos = 32'd2500;
    set_ldr(1000, 800, 2000, 2000);
    no_move("lim_max");
    pan_pos = 32'd500;
    set_ldr(800, 1000, 2000, 2000);
    no_move("lim_min");

    pan_pos = 32'd1500;
    set_ldr(1000, 800, 2000, 2000);
    push("lim_ramp", C_NONE, 3'd2, 1);
    push("lim_ramp", C_PCW, 3'd3, 3);
    strobe();
    tick(3);
    pan_pos = 32'd2500;
    push("lim_ramp", C_NONE, 3'd4, 4);
    push("lim_ramp", C_NONE, 3'd1, 1);
    tick(5);
    pan_pos = 32'd1500;

    // Pan granted (pointer -> tilt), then EN drops mid-move.
    set_ldr(1000, 800, 2000, 2000);
    push("en_drop", C_NONE, 3'd2, 1);
    push("en_drop", C_PCW, 3'd3, 4);
    strobe();
    tick(4);
    EN = 1'b0;
    push("en_off", C_NONE, 3'd0, 2);
    tick(2);
    EN = 1'b1;
    push("en_on", C_NONE, 3'd1, 1);
    tick(1);
    set_ldr(1000, 800, 800, 1000);
    move_seq("rr_kept", C_TCCW);

    // Pan granted (pointer -> tilt); strobe during MOVE must not disturb it.
    push("mv_strobe", C_NONE, 3'd2, 1);
    push("mv_strobe", C_PCW, 3'd3, 3);
    strobe();
    tick(3);
    set_ldr(0, 0, 0, 0);
    sample_valid = 1'b1;
    push("mv_strobe", C_PCW, 3'd3, 1);
    tick(1);
    sample_valid = 1'b0;
    push("mv_strobe", C_PCW, 3'd3, 4);
    tick(4);
    push("mv_strobe", C_NONE, 3'd4, 2);
    tick(2);
    RST = 1'b1;
    push("rst_settle", C_NONE, 3'd0, 1);
    tick(1);
    RST = 1'b0;
    push("rst_release", C_NONE, 3'd1, 1);
    tick(1);
    set_ldr(1000, 800, 800, 1000);
    move_seq("after_rst", C_PCW);

    total++;
    assert (sb_q.size() == 0)
    else begin bad++; $error("FAIL sb_drain got=%0d exp=0", sb_q.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
